// File: rtl/mem_port_responder.sv
// mem_port_responder: memory-side responder for the CPU control FSM.
// Performs ROM reads, RAM reads and RAM writes requested by the controller's
// enable/strobe lines, with the address muxed between PC and IR operand.
// Optional feature macro: MEM_ACCESS_COUNT_EN (per-class access counters).
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   rom_ena, rom_read            ROM select / read strobe
//   ram_ena, ram_read, ram_write RAM select / read / write strobes
//   ad_sel                       0 = pc_addr, 1 = ir_addr
//   pc_addr, ir_addr             candidate addresses
//   wdata                        RAM write data
//   rom_load_en/addr/data        ROM preload write port
//   rdata, rdata_valid           registered read data and one-cycle valid
//   bus_err                      sticky illegal-strobe flag
//   acc_state                    registered access class of the last cycle
//   rom_rd_cnt, ram_rd_cnt, ram_wr_cnt  (MEM_ACCESS_COUNT_EN only)
module mem_port_responder #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_ena,
  input  logic          rom_read,
  input  logic          ram_ena,
  input  logic          ram_read,
  input  logic          ram_write,
  input  logic          ad_sel,
  input  logic [AW-1:0] pc_addr,
  input  logic [AW-1:0] ir_addr,
  input  logic [DW-1:0] wdata,
  input  logic          rom_load_en,
  input  logic [AW-1:0] rom_load_addr,
  input  logic [DW-1:0] rom_load_data,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          bus_err,
  output logic [1:0]    acc_state
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]   rom_rd_cnt,
  output logic [15:0]   ram_rd_cnt,
  output logic [15:0]   ram_wr_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ROM_RD = 2'b01,
    ST_RAM_RD = 2'b10,
    ST_RAM_WR = 2'b11
  } acc_e;

  logic [DW-1:0] rom_mem [DEPTH];
  logic [DW-1:0] ram_mem [DEPTH];

  acc_e          state_q, state_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          bus_err_q, bus_err_d;
  logic [AW-1:0] prev_addr_q;

  logic [AW-1:0] addr_c;
  logic          illegal_c;
  logic          new_access_c;
  logic          ram_we_c;

  assign addr_c = ad_sel ? ir_addr : pc_addr;

  // Strobe pattern checks; any hit voids the cycle.
  assign illegal_c = (rom_ena & ram_ena)
                   | (ram_read & ram_write)
                   | (rom_read & ~rom_ena)
                   | ((ram_read | ram_write) & ~ram_ena)
                   | (rom_read & (ram_read | ram_write));

  // Classification, read data selection and error flag.
  always_comb begin
    state_d       = ST_IDLE;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_err_d     = bus_err_q | illegal_c;
    if (!illegal_c) begin
      if (rom_read) begin
        state_d       = ST_ROM_RD;
        rdata_d       = rom_mem[addr_c];
        rdata_valid_d = 1'b1;
      end else if (ram_read) begin
        state_d       = ST_RAM_RD;
        rdata_d       = ram_mem[addr_c];
        rdata_valid_d = 1'b1;
      end else if (ram_write) begin
        state_d       = ST_RAM_WR;
      end
    end
  end

  assign new_access_c = (state_d != state_q) || (addr_c != prev_addr_q);

  // A write in flight is dropped if reset is high at the edge.
  assign ram_we_c = (state_d == ST_RAM_WR) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      prev_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      bus_err_q     <= bus_err_d;
      prev_addr_q   <= addr_c;
    end
  end

  // Memory arrays are not reset; the read above sees pre-edge contents.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram_mem[addr_c] <= wdata;
    end
    if (rom_load_en) begin
      rom_mem[rom_load_addr] <= rom_load_data;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign bus_err     = bus_err_q;
  assign acc_state   = state_q;

`ifdef MEM_ACCESS_COUNT_EN
  logic [CW-1:0] rom_rd_cnt_q, rom_rd_cnt_d;
  logic [CW-1:0] ram_rd_cnt_q, ram_rd_cnt_d;
  logic [CW-1:0] ram_wr_cnt_q, ram_wr_cnt_d;

  // Count only the first cycle of each access; saturate at all-ones.
  always_comb begin
    rom_rd_cnt_d = rom_rd_cnt_q;
    ram_rd_cnt_d = ram_rd_cnt_q;
    ram_wr_cnt_d = ram_wr_cnt_q;
    if (new_access_c) begin
      if (state_d == ST_ROM_RD && rom_rd_cnt_q != '1) rom_rd_cnt_d = rom_rd_cnt_q + CW'(1);
      if (state_d == ST_RAM_RD && ram_rd_cnt_q != '1) ram_rd_cnt_d = ram_rd_cnt_q + CW'(1);
      if (state_d == ST_RAM_WR && ram_wr_cnt_q != '1) ram_wr_cnt_d = ram_wr_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_rd_cnt_q <= '0;
      ram_rd_cnt_q <= '0;
      ram_wr_cnt_q <= '0;
    end else begin
      rom_rd_cnt_q <= rom_rd_cnt_d;
      ram_rd_cnt_q <= ram_rd_cnt_d;
      ram_wr_cnt_q <= ram_wr_cnt_d;
    end
  end

  assign rom_rd_cnt = rom_rd_cnt_q;
  assign ram_rd_cnt = ram_rd_cnt_q;
  assign ram_wr_cnt = ram_wr_cnt_q;
`else
  // Access tracking has no consumer without the counters.
  logic unused_new_access;
  assign unused_new_access = new_access_c;
`endif

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed testbench for mem_port_responder.
module tb_mem_port_responder;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_ena, rom_read, ram_ena, ram_read, ram_write, ad_sel;
  logic [AW-1:0] pc_addr, ir_addr, rom_load_addr;
  logic [DW-1:0] wdata, rom_load_data;
  logic          rom_load_en;
  logic [DW-1:0] rdata;
  logic          rdata_valid, bus_err;
  logic [1:0]    acc_state;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0]   rom_rd_cnt, ram_rd_cnt, ram_wr_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_responder #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .rom_ena(rom_ena), .rom_read(rom_read),
    .ram_ena(ram_ena), .ram_read(ram_read), .ram_write(ram_write),
    .ad_sel(ad_sel), .pc_addr(pc_addr), .ir_addr(ir_addr), .wdata(wdata),
    .rom_load_en(rom_load_en), .rom_load_addr(rom_load_addr),
    .rom_load_data(rom_load_data),
    .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .acc_state(acc_state)
`ifdef MEM_ACCESS_COUNT_EN
    , .rom_rd_cnt(rom_rd_cnt), .ram_rd_cnt(ram_rd_cnt), .ram_wr_cnt(ram_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lines();
    rom_ena = 0; rom_read = 0; ram_ena = 0; ram_read = 0; ram_write = 0;
    rom_load_en = 0;
  endtask

  task automatic do_reset();
    idle_lines();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rom_load_en = 1; rom_load_addr = a; rom_load_data = d;
    tick();
    rom_load_en = 0;
  endtask

  task automatic test_reset();
    ad_sel = 0; pc_addr = 0; ir_addr = 0; wdata = 0;
    rom_load_addr = 0; rom_load_data = 0;
    do_reset();
    tests_run++;
    if (rdata !== 8'h00 || rdata_valid !== 1'b0 || bus_err !== 1'b0 || acc_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_values: got rdata=%h v=%b err=%b st=%b, want 00 0 0 00",
               rdata, rdata_valid, bus_err, acc_state);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    preload(5'd3, 8'hA5);
    ad_sel = 0; pc_addr = 5'd3; rom_ena = 1; rom_read = 1;
    tick();
    tests_run++;
    if (rdata !== 8'hA5 || rdata_valid !== 1'b1 || acc_state !== 2'b01) begin
      tests_failed++;
      $display("FAIL fetch_data: got rdata=%h v=%b st=%b, want a5 1 01", rdata, rdata_valid, acc_state);
    end
    idle_lines();
    tick();
    tests_run++;
    if (rdata !== 8'hA5 || rdata_valid !== 1'b0 || acc_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL fetch_hold: got rdata=%h v=%b st=%b, want a5 0 00", rdata, rdata_valid, acc_state);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    ad_sel = 1; ir_addr = 5'd5; wdata = 8'h3C;
    ram_ena = 1; ram_write = 1;
    tick();
    tick();
    tests_run++;
    if (acc_state !== 2'b11 || rdata_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_state: got st=%b v=%b, want 11 0", acc_state, rdata_valid);
    end
    wdata = 8'h00; ram_write = 0; ram_read = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (rdata !== 8'h3C || rdata_valid !== 1'b1 || acc_state !== 2'b10) begin
        tests_failed++;
        $display("FAIL load_cycle%0d: got rdata=%h v=%b st=%b, want 3c 1 10", i, rdata, rdata_valid, acc_state);
      end
    end
    idle_lines();
    tick();
    tests_run++;
    if (rdata_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_valid_drop: got v=%b, want 0", rdata_valid);
    end
`ifdef MEM_ACCESS_COUNT_EN
    tests_run++;
    if (ram_wr_cnt !== 16'd1 || ram_rd_cnt !== 16'd1 || rom_rd_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL store_load_cnt: got wr=%0d rd=%0d rom=%0d, want 1 1 0", ram_wr_cnt, ram_rd_cnt, rom_rd_cnt);
    end
`endif
  endtask

  task automatic test_illegal();
    // {rom_ena, rom_read, ram_ena, ram_read, ram_write}
    logic [4:0] pats [6];
    logic [4:0] p;
    pats[0] = 5'b10100; pats[1] = 5'b00111; pats[2] = 5'b01000;
    pats[3] = 5'b00010; pats[4] = 5'b00001; pats[5] = 5'b11110;
    do_reset();
    ad_sel = 1; ir_addr = 5'd7; wdata = 8'h11;
    ram_ena = 1; ram_write = 1;
    tick();
    wdata = 8'hEE; ram_read = 1;
    tick();
    tests_run++;
    if (bus_err !== 1'b1 || rdata_valid !== 1'b0 || acc_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL illegal_rw: got err=%b v=%b st=%b, want 1 0 00", bus_err, rdata_valid, acc_state);
    end
    ram_write = 0;
    tick();
    tests_run++;
    if (rdata !== 8'h11 || rdata_valid !== 1'b1 || bus_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_no_write: got rdata=%h v=%b err=%b, want 11 1 1", rdata, rdata_valid, bus_err);
    end
    idle_lines();
    tick();
    tests_run++;
    if (bus_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got err=%b, want 1", bus_err);
    end
    // Enables without strobes, and preload, are legal idle cycles.
    do_reset();
    rom_ena = 1; rom_load_en = 1;
    tick();
    rom_ena = 0; ram_ena = 1;
    tick();
    tests_run++;
    if (bus_err !== 1'b0 || acc_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL enable_only_idle: got err=%b st=%b, want 0 00", bus_err, acc_state);
    end
    for (int i = 0; i < 6; i++) begin
      do_reset();
      p = pats[i];
      {rom_ena, rom_read, ram_ena, ram_read, ram_write} = p;
      tick();
      idle_lines();
      tests_run++;
      if (bus_err !== 1'b1 || acc_state !== 2'b00 || rdata_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_pat%0d: got err=%b st=%b v=%b, want 1 00 0", i, bus_err, acc_state, rdata_valid);
      end
    end
  endtask

  task automatic test_addr_mux();
    do_reset();
    preload(5'd2, 8'h01);
    preload(5'd9, 8'h02);
    pc_addr = 5'd2; ir_addr = 5'd9; ad_sel = 0;
    rom_ena = 1; rom_read = 1;
    tick();
    tests_run++;
    if (rdata !== 8'h01 || rdata_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mux_pc: got rdata=%h v=%b, want 01 1", rdata, rdata_valid);
    end
    ad_sel = 1;
    tick();
    tests_run++;
    if (rdata !== 8'h02 || rdata_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mux_ir: got rdata=%h v=%b, want 02 1", rdata, rdata_valid);
    end
    idle_lines();
    tick();
`ifdef MEM_ACCESS_COUNT_EN
    tests_run++;
    if (rom_rd_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL mux_cnt: got rom=%0d, want 2", rom_rd_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    preload(5'd3, 8'hA5);
    ad_sel = 1; ir_addr = 5'd4; wdata = 8'h00; ram_ena = 1; ram_write = 1;
    tick();
    ram_ena = 0; ram_write = 0; rom_read = 1;   // illegal: sets bus_err
    tick();
    rom_read = 0; rom_ena = 1; rom_read = 1; ad_sel = 0; pc_addr = 5'd3;
    tick();
    tests_run++;
    if (rdata !== 8'hA5 || bus_err !== 1'b1 || acc_state !== 2'b01) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got rdata=%h err=%b st=%b, want a5 1 01", rdata, bus_err, acc_state);
    end
    idle_lines();
    ad_sel = 1; ir_addr = 5'd4; wdata = 8'hFF; ram_ena = 1; ram_write = 1;
    #2;
    rst = 1;
    #1;
    tests_run++;
    if (rdata !== 8'h00 || rdata_valid !== 1'b0 || bus_err !== 1'b0 || acc_state !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_reset: got rdata=%h v=%b err=%b st=%b, want 00 0 0 00",
               rdata, rdata_valid, bus_err, acc_state);
    end
    tick();
    idle_lines();
    rst = 0;
    ram_ena = 1; ram_read = 1;
    tick();
    tests_run++;
    if (rdata !== 8'h00 || rdata_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_aborted: got rdata=%h v=%b, want 00 1", rdata, rdata_valid);
    end
    idle_lines();
  endtask

  task automatic test_collision();
    do_reset();
    preload(5'd6, 8'h10);
    rom_load_en = 1; rom_load_addr = 5'd6; rom_load_data = 8'h20;
    ad_sel = 0; pc_addr = 5'd6; rom_ena = 1; rom_read = 1;
    tick();
    rom_load_en = 0;
    tests_run++;
    if (rdata !== 8'h10) begin
      tests_failed++;
      $display("FAIL collision_old: got rdata=%h, want 10", rdata);
    end
    tick();
    tests_run++;
    if (rdata !== 8'h20 || rdata_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_new: got rdata=%h v=%b, want 20 1", rdata, rdata_valid);
    end
    idle_lines();
    tick();
  endtask

  initial begin
    rst = 1;
    idle_lines();
    test_reset();
    test_fetch();
    test_store_load();
    test_illegal();
    test_addr_mux();
    test_reset_mid_write();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
Name: mem_port_responder

Overview:
- Memory-side responder for the CPU control FSM. It consumes the controller's enable and strobe lines (rom_ena/rom_read, ram_ena/ram_read/ram_write, ad_sel) and performs the requested ROM read, RAM read or RAM write.
- It selects the address between the PC and the IR operand field, returns registered read data with a valid pulse, and flags illegal strobe combinations.
- A ROM preload port fills instruction memory before the CPU is released from reset.

Parameters:
- AW, 5, address width; ROM and RAM depth are 2**AW each.
- DW, 8, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_ena  in  1  ROM select.
- rom_read  in  1  ROM read strobe.
- ram_ena  in  1  RAM select.
- ram_read  in  1  RAM read strobe.
- ram_write  in  1  RAM write strobe.
- ad_sel  in  1  address select: 0 = pc_addr, 1 = ir_addr.
- pc_addr  in  AW  program counter address.
- ir_addr  in  AW  operand address from the instruction register.
- wdata  in  DW  RAM write data (register/accumulator bus).
- rom_load_en  in  1  ROM preload write enable.
- rom_load_addr  in  AW  ROM preload address.
- rom_load_data  in  DW  ROM preload data.
- rdata  out  DW  registered read data.
- rdata_valid  out  1  high for one cycle after each accepted read cycle.
- bus_err  out  1  sticky illegal-strobe flag.
- acc_state  out  2  current access state: 00 IDLE, 01 ROM_RD, 10 RAM_RD, 11 RAM_WR.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rdata = 0, rdata_valid = 0, bus_err = 0, acc_state = IDLE, all counters = 0. ROM and RAM contents are not reset.
- Address: addr = ad_sel ? ir_addr : pc_addr. It is evaluated combinationally each cycle.
- Legal cycle patterns. Each cycle is classified as one of:
  - ROM_RD: rom_ena & rom_read, with RAM lines low.
  - RAM_RD: ram_ena & ram_read, with ram_write and rom_ena low.
  - RAM_WR: ram_ena & ram_write, with ram_read and rom_ena low.
  - IDLE: all strobes low. An enable without a strobe also counts as IDLE.
- Illegal cycle patterns. Any of the following sets bus_err on the next edge; the cycle is ignored (no read, no write, acc_state -> IDLE):
  - rom_ena & ram_ena;
  - ram_read & ram_write;
  - a strobe without its enable;
  - rom_read together with any RAM strobe.
- Once set, bus_err stays high until rst.
- Read latency is 1 cycle:
  - A read classified in cycle N loads rdata at the end of cycle N; rdata_valid is high in cycle N+1.
  - Repeated identical read cycles (e.g. the controller holding strobes for two states) each produce a valid pulse, so rdata_valid stays high back-to-back.
  - Outside reads, rdata holds its last value and rdata_valid = 0.
- Writes:
  - RAM[addr] <= wdata at the end of each RAM_WR cycle. A repeated identical write is idempotent.
  - Read-after-write: a RAM_RD in cycle N+1 to the address written in cycle N returns the new data.
- acc_state FSM:
  - Registers the classification of the current cycle: IDLE, ROM_RD, RAM_RD or RAM_WR.
  - Any state can go to any state in one cycle; illegal cycles go to IDLE.
  - A cycle is a "new access" when its class differs from acc_state, or its addr differs from the previous cycle's addr. Otherwise it is a continuation.
- ROM preload:
  - ROM[rom_load_addr] <= rom_load_data when rom_load_en is high.
  - If the same cycle has a ROM_RD to the same address, the read returns the old contents.
  - rom_load_en has no effect on bus_err.
- Reset mid-operation: a write in flight is not committed once rst is asserted, and a pending rdata_valid is cleared.
- Address wrap is not applicable: the full 2**AW space is populated.

Optional Feature:
- Macro: MEM_ACCESS_COUNT_EN.
- When defined, adds three outputs: rom_rd_cnt[15:0], ram_rd_cnt[15:0], ram_wr_cnt[15:0].
  - Each counter increments once per new access of its class; continuation cycles are not counted.
  - Counters saturate at 16'hFFFF.
  - Counters reset to 0 on rst.
- When not defined, these outputs and their logic do not exist; all other behaviour is identical.

Test Plan:
- Preload and fetch: preload ROM[3] = 8'hA5; pc_addr = 3, ad_sel = 0, single ROM_RD cycle -> next cycle rdata = 8'hA5, rdata_valid = 1 for exactly 1 cycle.
- Store then load: RAM_WR for 2 cycles, ir_addr = 5, ad_sel = 1, wdata = 8'h3C; then RAM_RD for 2 cycles at ir_addr = 5 -> rdata = 8'h3C with rdata_valid high 2 cycles; ram_wr_cnt = 1, ram_rd_cnt = 1 (with MEM_ACCESS_COUNT_EN).
- Illegal pattern: ram_ena = 1, ram_read = 1, ram_write = 1 at addr 7 (RAM[7] = 8'h11) -> RAM[7] stays 8'h11, rdata_valid = 0, bus_err = 1 and remains 1 through later legal cycles until rst.
- Address mux: pc_addr = 2, ir_addr = 9, ROM[2] = 8'h01, ROM[9] = 8'h02; ROM_RD with ad_sel = 0 then ad_sel = 1 -> rdata 8'h01 then 8'h02; rom_rd_cnt = 2.
- Reset mid-write: assert rst asynchronously during a RAM_WR of 8'hFF to addr 4 (prior value 8'h00), before the clock edge -> RAM[4] remains 8'h00; rdata = 0, bus_err = 0, acc_state = IDLE immediately.
- Preload/read collision: ROM[6] = 8'h10; same cycle rom_load writes 8'h20 to addr 6 and ROM_RD at addr 6 -> rdata = 8'h10; the next ROM_RD returns 8'h20.
